// File: rtl/can_bit_stuffer_if.sv
// Serializer-side and line-side signals of the CAN transmit bit stuffer.
// The master is the frame serializer / bit timer; the slave is the stuffer.
interface can_bit_stuffer_if #(
  parameter int CNT_W = 8
);
  logic             tx_point;
  logic             start;
  logic             in_valid;
  logic             in_bit;
  logic             in_last;
  logic             stuff_en;
  logic             in_ready;
  logic             tx_bit;
  logic             stuff_flag;
  logic             busy;
  logic             done;
  logic             underrun;
  logic [CNT_W-1:0] stuff_cnt;

  modport master (
    output tx_point, start, in_valid, in_bit, in_last, stuff_en,
    input  in_ready, tx_bit, stuff_flag, busy, done, underrun, stuff_cnt
  );

  modport slave (
    input  tx_point, start, in_valid, in_bit, in_last, stuff_en,
    output in_ready, tx_bit, stuff_flag, busy, done, underrun, stuff_cnt
  );
endinterface

// File: rtl/can_bit_stuffer.sv
// Transmit-side CAN bit stuffer: after RUN_LEN identical bits in the stuffed
// region it inserts one complementary bit, stalling the serializer for that bit time.
module can_bit_stuffer #(
  parameter int RUN_LEN = 5,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  can_bit_stuffer_if.slave bus
);
  localparam int                RL_W    = $clog2(RUN_LEN + 1);
  localparam logic [RL_W-1:0]   RUN_MAX = RL_W'(RUN_LEN);
  localparam logic [RL_W-1:0]   RUN_ONE = RL_W'(1);
  localparam logic [RL_W-1:0]   RUN_NIL = {RL_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_NIL = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             run_bit_r, run_bit_s;
  logic [RL_W-1:0]  run_len_r, run_len_s;
  logic             en_q_r, en_q_s;
  logic             tx_bit_r, tx_bit_s;
  logic             stuff_flag_r, stuff_flag_s;
  logic             done_r, done_s;
  logic             underrun_r, underrun_s;
  logic [CNT_W-1:0] stuff_cnt_r, stuff_cnt_s;
  logic             pending_s;
  logic             ready_s;

  // A stuff bit is owed once the run is full and the last data bit was stuffable.
  assign pending_s = (run_len_r == RUN_MAX) && en_q_r;
  assign ready_s   = (state_r == ST_DATA) && bus.tx_point && !pending_s;

  // Next-state and next-output logic, evaluated only at bit-time strobes.
  always_comb begin
    state_s      = state_r;
    run_bit_s    = run_bit_r;
    run_len_s    = run_len_r;
    en_q_s       = en_q_r;
    tx_bit_s     = tx_bit_r;
    stuff_flag_s = stuff_flag_r;
    done_s       = 1'b0;
    underrun_s   = 1'b0;
    stuff_cnt_s  = stuff_cnt_r;
    case (state_r)
      ST_IDLE: begin
        tx_bit_s     = 1'b1;
        stuff_flag_s = 1'b0;
        if (bus.start) begin
          state_s     = ST_DATA;
          run_len_s   = RUN_NIL;
          en_q_s      = 1'b0;
          stuff_cnt_s = CNT_NIL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA, ST_TAIL: begin
        if (bus.tx_point) begin
          if (pending_s) begin
            tx_bit_s     = ~run_bit_r;
            stuff_flag_s = 1'b1;
            run_bit_s    = ~run_bit_r;
            run_len_s    = RUN_ONE;
            stuff_cnt_s  = (stuff_cnt_r == CNT_MAX) ? CNT_MAX : stuff_cnt_r + CNT_ONE;
          end else if (ready_s && bus.in_valid) begin
            tx_bit_s     = bus.in_bit;
            stuff_flag_s = 1'b0;
            if ((bus.in_bit == run_bit_r) && (run_len_r != RUN_NIL)) begin
              run_len_s = (run_len_r == RUN_MAX) ? RUN_MAX : run_len_r + RUN_ONE;
            end else begin
              run_len_s = RUN_ONE;
            end
            run_bit_s = bus.in_bit;
            en_q_s    = bus.stuff_en;
            state_s   = bus.in_last ? ST_TAIL : ST_DATA;
          end else begin
            // Tail finished cleanly, or the serializer had nothing to give.
            tx_bit_s     = 1'b1;
            stuff_flag_s = 1'b0;
            state_s      = ST_IDLE;
            if (state_r == ST_TAIL) begin
              done_s = 1'b1;
            end else begin
              underrun_s = 1'b1;
            end
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        tx_bit_s     = 1'b1;
        stuff_flag_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      run_bit_r    <= 1'b1;
      run_len_r    <= RUN_NIL;
      en_q_r       <= 1'b0;
      tx_bit_r     <= 1'b1;
      stuff_flag_r <= 1'b0;
      done_r       <= 1'b0;
      underrun_r   <= 1'b0;
      stuff_cnt_r  <= CNT_NIL;
    end else begin
      state_r      <= state_s;
      run_bit_r    <= run_bit_s;
      run_len_r    <= run_len_s;
      en_q_r       <= en_q_s;
      tx_bit_r     <= tx_bit_s;
      stuff_flag_r <= stuff_flag_s;
      done_r       <= done_s;
      underrun_r   <= underrun_s;
      stuff_cnt_r  <= stuff_cnt_s;
    end
  end

  assign bus.in_ready   = ready_s;
  assign bus.tx_bit     = tx_bit_r;
  assign bus.stuff_flag = stuff_flag_r;
  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.done       = done_r;
  assign bus.underrun   = underrun_r;
  assign bus.stuff_cnt  = stuff_cnt_r;
endmodule

// File: tb/tb_can_bit_stuffer.sv
// Scoreboard bench for can_bit_stuffer: a stream-level model predicts every line
// bit per frame; a monitor compares each post-strobe output against the queue.
module tb_can_bit_stuffer;
  localparam int RUN_LEN = 5;
  localparam int CNT_W   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  can_bit_stuffer_if #(.CNT_W(CNT_W)) bus ();

  can_bit_stuffer #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic             tx;
    logic             sf;
    logic             dn;
    logic             ur;
    logic             bz;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic rdy;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  e_m;
  obs_t  act_m;
  int    n_chk = 0;
  int    n_pass = 0;
  logic  tp_q = 1'b0;
  logic  rdy_q = 1'b0;
  logic  last_tx = 1'b1;
  logic  last_sf = 1'b0;
  logic  fb[$];
  logic  fe[$];
  int    ur_idx = -1;
  int    final_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic push_exp(input logic tx, input logic sf, input logic dn, input logic ur,
                          input logic bz, input int cnt, input logic rdy);
    exp_t e;
    e.o.tx  = tx;
    e.o.sf  = sf;
    e.o.dn  = dn;
    e.o.ur  = ur;
    e.o.bz  = bz;
    e.o.cnt = CNT_W'(cnt);
    e.rdy   = rdy;
    exp_q.push_back(e);
  endtask

  // Length of the run of identical bits at the end of the emitted line stream.
  function automatic int trailing_run(input logic line[$]);
    int n = 0;
    for (int k = line.size() - 1; k >= 0; k--) begin
      if (line[k] == line[line.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  // Reference model: build the whole stuffed line stream for the current frame.
  task automatic model_frame();
    logic line[$];
    int   sc = 0;
    int   n = (ur_idx >= 0) ? ur_idx : fb.size();
    for (int i = 0; i < n; i++) begin
      line.push_back(fb[i]);
      push_exp(fb[i], 1'b0, 1'b0, 1'b0, 1'b1, sc, 1'b1);
      if (fe[i] && trailing_run(line) >= RUN_LEN) begin
        sc++;
        line.push_back(~fb[i]);
        push_exp(~fb[i], 1'b1, 1'b0, 1'b0, 1'b1, sc, 1'b0);
      end
    end
    if (ur_idx >= 0) push_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sc, 1'b1);
    else             push_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, sc, 1'b0);
    final_cnt = sc;
  endtask

  task automatic drive_data(input int idx);
    int avail = (ur_idx >= 0) ? ur_idx : fb.size();
    bus.in_valid = (idx < avail);
    bus.in_bit   = (idx < fb.size()) ? fb[idx] : 1'b1;
    bus.stuff_en = (idx < fb.size()) ? fe[idx] : 1'b0;
    bus.in_last  = (idx == fb.size() - 1);
  endtask

  task automatic check_reset_values(input string name);
    chk(name, 32'({bus.tx_bit, bus.stuff_flag, bus.busy, bus.done, bus.underrun,
                   bus.in_ready, bus.stuff_cnt}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {CNT_W{1'b0}}}));
  endtask

  task automatic run_frame(input bit rst_mid);
    int idx = 0;
    int cyc = 0;
    int gap = 0;
    bit took;
    model_frame();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.tx_point = 1'($urandom_range(0, 1));
    drive_data(0);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.tx_point = 1'b0;
    while (bus.busy) begin
      if (cyc >= 800) begin
        n_chk++;
        $display("FAIL frame_timeout: actual=%0d cycles required<800", cyc);
        break;
      end
      bus.tx_point = (gap == 0);
      gap = bus.tx_point ? $urandom_range(0, 2) : gap - 1;
      drive_data(idx);
      #1 took = bus.tx_point && bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (took) idx++;
      cyc++;
      if (rst_mid && bus.stuff_flag) begin
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_mid_frame");
        exp_q.delete();
        final_cnt = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.tx_point = k[0];
      @(negedge clk);
    end
    bus.tx_point = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("busy_after_frame", 32'(bus.busy), 32'd0);
    chk("stuff_cnt_after_frame", 32'(bus.stuff_cnt), 32'(final_cnt));
  endtask

  task automatic set_frame(input logic [31:0] bits, input int len, input logic en, input int ur);
    fb.delete();
    fe.delete();
    for (int i = 0; i < len; i++) begin
      fb.push_back(bits[i]);
      fe.push_back(en);
    end
    ur_idx = ur;
  endtask

  task automatic rand_frame();
    int   len = $urandom_range(1, 24);
    int   cut = $urandom_range(0, len);
    logic b = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 2) == 0) cut = len;
    fb.delete();
    fe.delete();
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      fb.push_back(b);
      fe.push_back(i < cut);
    end
    ur_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
  endtask

  // Capture strobe and handshake as seen just before each active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q  <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      tp_q  <= bus.tx_point && bus.busy;
      rdy_q <= bus.in_ready;
    end
  end

  // Monitor: compare outputs after every strobe, and check holds in between.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_tx = 1'b1;
      last_sf = 1'b0;
    end else begin
      act_m = {bus.tx_bit, bus.stuff_flag, bus.done, bus.underrun, bus.busy, bus.stuff_cnt};
      if (tp_q) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: actual=0x%0h required=none", act_m);
        end else begin
          e_m = exp_q.pop_front();
          chk("line_out", 32'(act_m), 32'(e_m.o));
          chk("in_ready", 32'(rdy_q), 32'(e_m.rdy));
          last_tx = e_m.o.tx;
          last_sf = e_m.o.sf;
        end
      end else begin
        chk("hold", 32'({bus.tx_bit, bus.stuff_flag, bus.done, bus.underrun}),
            32'({last_tx, last_sf, 2'b00}));
      end
    end
  end

  initial begin
    bus.tx_point = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b1;
    bus.in_last  = 1'b0;
    bus.stuff_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_in");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) bus.tx_point = 1'b1;
      @(negedge clk) bus.tx_point = 1'b0;
    end
    check_reset_values("idle_after_reset");

    set_frame(32'h0000_0020, 6, 1'b1, -1);  run_frame(1'b0);  // basic stuff
    set_frame(32'h0000_01E0, 9, 1'b1, -1);  run_frame(1'b0);  // stuff starts next run
    set_frame(32'h0000_03FF, 10, 1'b1, -1); run_frame(1'b0);  // long run
    set_frame(32'h0000_0000, 7, 1'b0, -1);  run_frame(1'b0);  // stuffing disabled
    set_frame(32'h0000_002A, 6, 1'b1, 2);   run_frame(1'b0);  // underrun at 3rd strobe
    set_frame(32'h0000_00FF, 8, 1'b1, -1);  run_frame(1'b1);  // reset during stuff bit
    set_frame(32'h0000_0000, 1, 1'b1, 0);   run_frame(1'b0);  // underrun at first strobe

    for (int f = 0; f < 40; f++) begin
      rand_frame();
      run_frame(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
